i2s_dac_tx: RTL and testbench

- Serializes 16-bit stereo PCM samples onto the ADAU1761 DAC serial data line (AC_GPIO0) in I2S format.
- The codec is bit-clock master; this block only follows it. BCLK (AC_GPIO2) and LRCLK (AC_GPIO3) come from the codec and are oversampled in the clk_48 domain.
- Upstream logic (filters, loopback) delivers one left/right pair per frame through a valid/ready handshake. The block is the transmit-side counterpart of the ADC line-in deserializer.

---
 rtl/i2s_dac_tx.sv | 137 +++++++++++++
 tb/tb_i2s_dac_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
`timescale 1ns/1ps
// I2S transmit serializer for the codec DAC line. It follows the codec-mastered BCLK/LRCLK
// and takes one stereo pair per frame from a single-entry valid/ready holding register.
module i2s_dac_tx #(
  parameter int SAMPLE_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_48,
  input  logic                rst_n,
  input  logic                ac_bclk,
  input  logic                ac_lrclk,
  output logic                ac_sdata,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                frame_start,
  output logic                underrun
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrclk_sync_q, lrclk_sync_d;
  logic                   bclk_dly_q, bclk_dly_d;
  logic                   lrclk_cap_q, lrclk_cap_d;
  logic                   lr_prev_q, lr_prev_d;
  logic [SAMPLE_W-1:0]    hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0]    hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0]    right_buf_q, right_buf_d;
  logic [SAMPLE_W-1:0]    shift_q, shift_d;
  logic                   hold_full_q, hold_full_d;
  logic                   sdata_q, sdata_d;
  logic                   frame_start_q, frame_start_d;
  logic                   underrun_q, underrun_d;
  logic [SAMPLE_W-1:0]    word;
  logic                   bclk_s, lrclk_s, rise, fall, boundary;

  always_comb begin
    bclk_sync_d   = {bclk_sync_q[SYNC_STAGES-2:0], ac_bclk};
    lrclk_sync_d  = {lrclk_sync_q[SYNC_STAGES-2:0], ac_lrclk};
    bclk_s        = bclk_sync_q[SYNC_STAGES-1];
    lrclk_s       = lrclk_sync_q[SYNC_STAGES-1];
    bclk_dly_d    = bclk_s;
    rise          = bclk_s & ~bclk_dly_q;
    fall          = ~bclk_s & bclk_dly_q;
    lrclk_cap_d   = rise ? lrclk_s : lrclk_cap_q;
    boundary      = fall && (lrclk_cap_q != lr_prev_q);

    state_d       = state_q;
    lr_prev_d     = lr_prev_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    right_buf_d   = right_buf_q;
    shift_d       = shift_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    word          = '0;

    // Write and frame-start transfer are exclusive: a write needs the holding register empty.
    if (s_valid && !hold_full_q) begin
      hold_l_d    = s_left;
      hold_r_d    = s_right;
      hold_full_d = 1'b1;
    end

    if (fall) begin
      lr_prev_d = lrclk_cap_q;
      if (boundary && !lrclk_cap_q) begin
        frame_start_d = 1'b1;
        state_d       = RUN;
        if (hold_full_q) begin
          word        = hold_l_q;
          right_buf_d = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          right_buf_d = '0;
          underrun_d  = (state_q == RUN);
        end
        sdata_d = word[SAMPLE_W-1];
        shift_d = {word[SAMPLE_W-2:0], 1'b0};
      end else if (boundary) begin
        sdata_d = right_buf_q[SAMPLE_W-1];
        shift_d = {right_buf_q[SAMPLE_W-2:0], 1'b0};
      end else begin
        sdata_d = shift_q[SAMPLE_W-1];
        shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
      end
      // Until the first full frame start the line stays quiet, so no partial word leaks out.
      if (state_d == IDLE) begin
        sdata_d = 1'b0;
        shift_d = '0;
      end
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bclk_sync_q   <= '0;
      lrclk_sync_q  <= '0;
      bclk_dly_q    <= 1'b0;
      lrclk_cap_q   <= 1'b0;
      lr_prev_q     <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      right_buf_q   <= '0;
      shift_q       <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bclk_sync_q   <= bclk_sync_d;
      lrclk_sync_q  <= lrclk_sync_d;
      bclk_dly_q    <= bclk_dly_d;
      lrclk_cap_q   <= lrclk_cap_d;
      lr_prev_q     <= lr_prev_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      right_buf_q   <= right_buf_d;
      shift_q       <= shift_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign ac_sdata    = sdata_q;
  assign s_ready     = ~hold_full_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
`timescale 1ns/1ps
// Bench for i2s_dac_tx: a behavioural codec drives BCLK/LRCLK, captures each slot's bits on
// BCLK rise, and frames are compared against the pairs the bench wrote.
module tb_i2s_dac_tx;
  localparam int W    = 16;
  localparam int HALF = 163;

  logic         clk_48 = 1'b0, rst_n = 1'b0;
  logic         ac_bclk, ac_lrclk, ac_sdata;
  logic [W-1:0] s_left = '0, s_right = '0;
  logic         s_valid = 1'b0;
  logic         s_ready, frame_start, underrun;

  int checks = 0, passed = 0;
  int slot_len = 32, frame_no = 0;
  logic [63:0] lbuf [128];
  logic [63:0] rbuf [128];
  int          flen [128];
  bit          lgot [128];
  bit          rgot [128];

  i2s_dac_tx #(.SAMPLE_W(W), .SYNC_STAGES(2)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .ac_bclk(ac_bclk), .ac_lrclk(ac_lrclk),
    .ac_sdata(ac_sdata), .s_left(s_left), .s_right(s_right), .s_valid(s_valid),
    .s_ready(s_ready), .frame_start(frame_start), .underrun(underrun));

  always #10 clk_48 = ~clk_48;

  // Codec: LRCLK moves on BCLK falls; the bit sampled on the first rise of a slot
  // still belongs to the previous slot (I2S one-bit delay).
  initial begin
    logic [63:0] cur;
    int cur_n, cur_f, len;
    bit cur_lr, b;
    ac_bclk = 1'b0; ac_lrclk = 1'b1;
    cur = '0; cur_n = 0; cur_f = 0; cur_lr = 1'b1; len = 32;
    #(HALF * 3);
    forever begin
      for (int s = 0; s < 2; s++) begin
        if (s == 0) begin frame_no++; len = slot_len; end
        ac_lrclk = (s == 1);
        for (int k = 1; k <= len; k++) begin
          #HALF; ac_bclk = 1'b1; b = ac_sdata;
          cur = {cur[62:0], b}; cur_n++;
          if (k == 1) begin
            if (cur_lr) begin rbuf[cur_f % 128] = cur; rgot[cur_f % 128] = 1'b1; end
            else begin lbuf[cur_f % 128] = cur; flen[cur_f % 128] = cur_n; lgot[cur_f % 128] = 1'b1; end
            cur = '0; cur_n = 0; cur_lr = (s == 1); cur_f = frame_no;
          end
          #HALF; ac_bclk = 1'b0;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected slot contents: the word MSB first, zero-padded or truncated to the slot length.
  function automatic logic [63:0] ser(input logic [W-1:0] w, input int len);
    logic [63:0] v;
    v = 64'(w);
    if (len >= W) return v << (len - W);
    return v >> (W - len);
  endfunction

  task automatic wait_fs(output bit ok, output int f);
    ok = 1'b0; f = -1;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk_48);
      if (frame_start) begin ok = 1'b1; f = frame_no; break; end
    end
  endtask

  task automatic fetch(input int f, output logic [63:0] lb, output logic [63:0] rb,
                       output int ln, output bit ok);
    for (int t = 0; t < 6000 && !(lgot[f % 128] && rgot[f % 128]); t++) @(posedge clk_48);
    ok = lgot[f % 128] && rgot[f % 128];
    lb = lbuf[f % 128]; rb = rbuf[f % 128]; ln = flen[f % 128];
  endtask

  task automatic write_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    s_left = l; s_right = r; s_valid = 1'b1;
    @(posedge clk_48); #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk_48);
    checks++; if (ac_sdata !== 1'b0) $display("FAIL reset_sdata got %b want 0", ac_sdata); else passed++;
    checks++; if (s_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", s_ready); else passed++;
    checks++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok; int f, ln; logic [63:0] lb, rb;
    @(negedge clk_48);
    write_pair(16'hA5C3, 16'h0F01);
    @(negedge clk_48);
    checks++; if (s_ready !== 1'b0) $display("FAIL basic_ready_after_write got %b want 0", s_ready); else passed++;
    wait_fs(ok, f);
    checks++; if (!ok || underrun !== 1'b0) $display("FAIL basic_fs ok=%0d underrun=%b want ok=1 underrun=0", ok, underrun); else passed++;
    checks++; if (s_ready !== 1'b1) $display("FAIL basic_ready_after_fs got %b want 1", s_ready); else passed++;
    fetch(f, lb, rb, ln, ok);
    checks++; if (!ok || lb !== ser(16'hA5C3, ln)) $display("FAIL basic_left got %h want %h", lb, ser(16'hA5C3, ln)); else passed++;
    checks++; if (!ok || rb !== ser(16'h0F01, ln)) $display("FAIL basic_right got %h want %h", rb, ser(16'h0F01, ln)); else passed++;
  endtask

  task automatic test_underrun();
    bit ok, bad; int f, ln; logic [63:0] lb, rb;
    wait_fs(ok, f);
    checks++; if (!ok || underrun !== 1'b1) $display("FAIL underrun_pulse ok=%0d got %b want 1", ok, underrun); else passed++;
    bad = 1'b0;
    for (int t = 0; t < 6000 && !(lgot[f % 128] && rgot[f % 128]); t++) begin
      @(negedge clk_48);
      if (s_ready !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) $display("FAIL underrun_ready got low want high throughout"); else passed++;
    fetch(f, lb, rb, ln, ok);
    checks++; if (!ok || lb !== 64'h0 || rb !== 64'h0) $display("FAIL underrun_silence got %h/%h want 0/0", lb, rb); else passed++;
  endtask

  task automatic test_stream();
    bit ok, hs; int f0, k, nfs, acc, ln;
    logic [W-1:0] pl [8];
    logic [W-1:0] pr [8];
    logic [63:0] lb, rb;
    for (int i = 0; i < 8; i++) begin pl[i] = W'($urandom); pr[i] = W'($urandom); end
    wait_fs(ok, f0);
    k = 0; nfs = 0; acc = 0;
    s_left = pl[0]; s_right = pr[0]; s_valid = 1'b1;
    for (int t = 0; t < 20000; t++) begin
      if (t > 0) begin
        @(negedge clk_48);
        if (frame_start) begin
          nfs++;
          checks++; if (underrun !== 1'b0) $display("FAIL stream_underrun frame %0d got 1 want 0", nfs); else passed++;
          checks++; if (acc != 1) $display("FAIL stream_accepts frame %0d got %0d want 1", nfs, acc); else passed++;
          checks++; if (s_ready !== 1'b1) $display("FAIL stream_ready_at_fs got %b want 1", s_ready); else passed++;
          acc = 0;
          if (nfs == 4) begin s_valid = 1'b0; break; end
        end
      end
      hs = s_ready;
      @(posedge clk_48); #1;
      if (hs) begin acc++; k++; s_left = pl[k % 8]; s_right = pr[k % 8]; end
    end
    s_valid = 1'b0;
    checks++; if (nfs != 4) $display("FAIL stream_frames got %0d want 4", nfs); else passed++;
    for (int i = 0; i < 4; i++) begin
      fetch(f0 + 1 + i, lb, rb, ln, ok);
      checks++;
      if (!ok || lb !== ser(pl[i], ln) || rb !== ser(pr[i], ln))
        $display("FAIL stream_data pair %0d got %h/%h want %h/%h", i, lb, rb, ser(pl[i], ln), ser(pr[i], ln));
      else passed++;
    end
  endtask

  task automatic test_exact();
    bit ok; int f, f2, ln; logic [63:0] lb, rb;
    wait_fs(ok, f);
    checks++; if (!ok || underrun !== 1'b1) $display("FAIL exact_underrun ok=%0d got %b want 1", ok, underrun); else passed++;
    write_pair(16'h8000, 16'h7FFF);
    wait_fs(ok, f2);
    checks++; if (!ok || f2 != f + 1 || underrun !== 1'b0) $display("FAIL exact_next_fs frame %0d underrun %b want frame %0d underrun 0", f2, underrun, f + 1); else passed++;
    fetch(f, lb, rb, ln, ok);
    checks++; if (!ok || lb !== 64'h0 || rb !== 64'h0) $display("FAIL exact_silent got %h/%h want 0/0", lb, rb); else passed++;
    fetch(f + 1, lb, rb, ln, ok);
    checks++; if (!ok || lb !== ser(16'h8000, ln) || rb !== ser(16'h7FFF, ln)) $display("FAIL exact_data got %h/%h want %h/%h", lb, rb, ser(16'h8000, ln), ser(16'h7FFF, ln)); else passed++;
  endtask

  task automatic test_slot_len();
    bit ok; int f, f1, f2, ln; logic [63:0] lb, rb;
    logic [W-1:0] l1, r1, l2, r2;
    l1 = W'($urandom) | 16'h8001; r1 = W'($urandom) | 16'h8001;
    l2 = W'($urandom) | 16'h8001; r2 = W'($urandom) | 16'h8001;
    wait_fs(ok, f);
    slot_len = 48;
    write_pair(l1, r1);
    wait_fs(ok, f1);
    checks++; if (!ok || f1 != f + 1 || underrun !== 1'b0) $display("FAIL slot48_fs frame %0d underrun %b want frame %0d underrun 0", f1, underrun, f + 1); else passed++;
    slot_len = 12;
    write_pair(l2, r2);
    wait_fs(ok, f2);
    checks++; if (!ok || f2 != f1 + 1 || underrun !== 1'b0) $display("FAIL slot12_fs frame %0d underrun %b want frame %0d underrun 0", f2, underrun, f1 + 1); else passed++;
    slot_len = 32;
    fetch(f1, lb, rb, ln, ok);
    checks++; if (!ok || ln != 48 || lb !== ser(l1, 48) || rb !== ser(r1, 48)) $display("FAIL slot48_data len %0d got %h/%h want %h/%h", ln, lb, rb, ser(l1, 48), ser(r1, 48)); else passed++;
    fetch(f2, lb, rb, ln, ok);
    checks++; if (!ok || ln != 12 || lb !== ser(l2, 12) || rb !== ser(r2, 12)) $display("FAIL slot12_data len %0d got %h/%h want %h/%h", ln, lb, rb, ser(l2, 12), ser(r2, 12)); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok, bad; int f, f1, f2, f3, ln; logic [63:0] lb, rb;
    logic [W-1:0] q_l, q_r;
    q_l = W'($urandom); q_r = W'($urandom);
    wait_fs(ok, f);
    write_pair(W'($urandom) | 16'h0FF0, W'($urandom));
    wait_fs(ok, f1);
    repeat (100) @(negedge clk_48);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ac_sdata !== 1'b0 || s_ready !== 1'b1 || underrun !== 1'b0) $display("FAIL midreset_async sdata=%b ready=%b underrun=%b want 0/1/0", ac_sdata, s_ready, underrun); else passed++;
    repeat (20) @(negedge clk_48);
    rst_n = 1'b1;
    bad = 1'b0; ok = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk_48);
      if (frame_start) begin ok = 1'b1; break; end
      if (ac_sdata !== 1'b0) bad = 1'b1;
    end
    f2 = frame_no;
    checks++; if (bad) $display("FAIL midreset_quiet got data want 0 until frame start"); else passed++;
    checks++; if (!ok || f2 != f1 + 1 || underrun !== 1'b0) $display("FAIL midreset_first_fs frame %0d underrun %b want frame %0d underrun 0", f2, underrun, f1 + 1); else passed++;
    write_pair(q_l, q_r);
    wait_fs(ok, f3);
    checks++; if (!ok || underrun !== 1'b0) $display("FAIL midreset_second_fs underrun %b want 0", underrun); else passed++;
    fetch(f2, lb, rb, ln, ok);
    checks++; if (!ok || lb !== 64'h0 || rb !== 64'h0) $display("FAIL midreset_silent got %h/%h want 0/0", lb, rb); else passed++;
    fetch(f3, lb, rb, ln, ok);
    checks++; if (!ok || lb !== ser(q_l, ln) || rb !== ser(q_r, ln)) $display("FAIL midreset_recover got %h/%h want %h/%h", lb, rb, ser(q_l, ln), ser(q_r, ln)); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_stream();
    test_exact();
    test_slot_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
